alu_op_driver: RTL and testbench
================================

// Module: alu_op_driver
// PURPOSE
//  Initiator for the 4-bit combinational ALU. Buffers operation requests (A, B, SEL),
//  drives them onto the ALU operand/select lines one at a time, and captures ALU OUT.
//  Returns each result in order on a valid/ready response channel.
//  Sits between a command source (test sequencer or CPU-side control) and the ALU instance.
// PARAMETERS
//  WIDTH  4  operand/result width; must match the ALU datapath
//  DEPTH  4  command FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1      single clock; all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      FIFO can accept; registered, = !full
//  cmd_a      in   WIDTH  operand A
//  cmd_b      in   WIDTH  operand B
//  cmd_sel    in   3      opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A
//  alu_a      out  WIDTH  to ALU A (registered)
//  alu_b      out  WIDTH  to ALU B (registered)
//  alu_sel    out  3      to ALU SEL (registered)
//  alu_out    in   WIDTH  from ALU OUT (combinational, valid in same cycle as alu_*)
//  rsp_valid  out  1      result available; held until accepted
//  rsp_ready  in   1      consumer accepts result
//  rsp_data   out  WIDTH  captured result
//  rsp_err    out  1      command had illegal opcode (101..111)
// BEHAVIOUR
//  Reset (rst=1 at an edge): FIFO emptied, FSM->IDLE. cmd_ready=0 while rst is high, then 1 on the
//   first edge after rst falls. alu_a/alu_b/alu_sel/rsp_data=0, rsp_valid=0, rsp_err=0.
//  Command accept: cmd_valid && cmd_ready at edge -> push. Push when full is impossible (ready low).
//   No bypass: a command always passes through the FIFO.
//  FSM IDLE: if FIFO non-empty -> pop; load alu_a/b/sel; -> DRIVE.
//  FSM DRIVE (one cycle): alu_* stable; at edge capture rsp_data = (sel legal ? alu_out : 0),
//   set rsp_err = sel illegal, set rsp_valid=1; -> RESP.
//  FSM RESP: hold rsp_* stable while !rsp_ready. On handshake: rsp_valid=0.
//   If FIFO non-empty, pop and load alu_* in the same edge -> DRIVE. Otherwise -> IDLE.
//  alu_* keep their last value in IDLE/RESP. They change only on a pop.
//  Latency: command accepted at edge t -> rsp_valid high after edge t+2.
//   Peak throughput is 1 op / 2 cycles.
//  Capacity: DEPTH in FIFO + 1 in flight (DRIVE/RESP).
//  Simultaneous push and pop on the same edge is legal at any occupancy below full.
//   Count is unchanged when both occur.
//  Width rules: ADD/SUB wrap modulo 2^WIDTH (no carry/borrow reported). Pointers wrap modulo DEPTH.
//  Illegal opcode: still driven to the ALU for one DRIVE cycle. Response is forced to data=0, err=1.
//  Reset mid-operation: in-flight and buffered commands are discarded, with no response.
//   rsp_valid is 0 after the reset edge.
// CONFIGURATION
//  ALU_DRV_CHECK_EN defined: adds output rsp_mismatch (1 bit, reset 0).
//   Internal golden model computes the expected result from the popped command.
//   rsp_mismatch=1 with the response when a legal op's alu_out differs from the model.
//  Undefined: port and model absent. Behaviour is otherwise identical.
// STRUCTURE
//  alu_drv_pkg: opcode localparams OP_ADD..OP_NOT, OP_LAST_LEGAL=3'b100,
//   FSM state enum {IDLE, DRIVE, RESP}.
//  Sub-module alu_cmd_fifo: sync FIFO, WIDTH*2+3 bits wide, DEPTH entries,
//   push/pop/full/empty, sync active-high reset.
// TESTING
//  1 Reset: rst=1 for 3 cycles -> cmd_ready=0, all outputs 0. cmd_ready=1 one cycle after rst=0.
//  2 ADD A=7 B=5, rsp_ready=1 -> alu_a=7, alu_b=5, alu_sel=000 during DRIVE.
//    rsp_data=C, rsp_err=0 at t+2.
//  3 SUB A=2 B=3 -> rsp_data=F (wrap). NOT A=A -> rsp_data=5. OR 9|6 -> F.
//  4 rsp_ready=0, push 6 cmds -> 5 accepted, cmd_ready=0 after the 5th.
//    Release rsp_ready -> all 5 results in order.
//  5 cmd_sel=110, A=3 B=1 -> rsp_data=0, rsp_err=1. The next legal cmd responds normally.
//  6 rst pulse while rsp_valid=1 with 3 queued -> rsp_valid=0 next cycle, no further responses.

Source files
------------

// File: rtl/alu_drv_pkg.sv
// Shared opcodes, FSM state type and opcode helpers for the ALU operation driver.
package alu_drv_pkg;

    localparam logic [2:0] OP_ADD        = 3'b000;
    localparam logic [2:0] OP_SUB        = 3'b001;
    localparam logic [2:0] OP_AND        = 3'b010;
    localparam logic [2:0] OP_OR         = 3'b011;
    localparam logic [2:0] OP_NOT        = 3'b100;
    localparam logic [2:0] OP_LAST_LEGAL = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    function automatic logic op_legal(input logic [2:0] sel);
        return sel <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO: combinational read of the head entry, occupancy count output.
module alu_cmd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage carries no reset; only pointers and occupancy are control state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/alu_op_driver.sv
// Buffers ALU commands, drives them to the combinational ALU one at a time, returns results in order.
// Optional feature: define ALU_DRV_CHECK_EN to add the rsp_mismatch golden-model check output.
module alu_op_driver
    import alu_drv_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
`ifdef ALU_DRV_CHECK_EN
    ,
    output logic             rsp_mismatch
`endif
);

    localparam int CW = 2*WIDTH + 3;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic [WIDTH-1:0] gate_result(input logic [2:0] sel,
                                                     input logic [WIDTH-1:0] r);
        return op_legal(sel) ? r : '0;
    endfunction

`ifdef ALU_DRV_CHECK_EN
    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0]       sel);
        case (sel)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NOT:  return ~a;
            default: return '0;
        endcase
    endfunction
`endif

    state_t          state;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   fifo_rdata;
    logic [AW:0]     fifo_count;
    logic [AW:0]     count_nxt;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [2:0]       head_sel;

    assign push = cmd_valid && cmd_ready && !full;
    // RESP can pop in the same edge as the handshake, giving back-to-back DRIVE.
    assign pop  = !empty && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign count_nxt = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    assign {head_a, head_b, head_sel} = fifo_rdata;

    alu_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({cmd_a, cmd_b, cmd_sel}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
`ifdef ALU_DRV_CHECK_EN
            rsp_mismatch <= 1'b0;
`endif
        end else begin
            cmd_ready <= (count_nxt != FULL_CNT);
            if (pop) begin
                alu_a   <= head_a;
                alu_b   <= head_b;
                alu_sel <= head_sel;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    rsp_data  <= gate_result(alu_sel, alu_out);
                    rsp_err   <= !op_legal(alu_sel);
                    rsp_valid <= 1'b1;
`ifdef ALU_DRV_CHECK_EN
                    rsp_mismatch <= op_legal(alu_sel) &&
                                    (alu_out != golden(alu_a, alu_b, alu_sel));
`endif
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? DRIVE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver: behavioural ALU, response scoreboard and literal checks.
module tb_alu_op_driver;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [2:0]       cmd_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
`ifdef ALU_DRV_CHECK_EN
    logic             rsp_mismatch;
`endif

    int checks = 0;
    int errors = 0;
    int n_rsp  = 0;
    logic [4:0] expq[$];

    always #5 clk = ~clk;

    alu_op_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef ALU_DRV_CHECK_EN
        ,
        .rsp_mismatch (rsp_mismatch)
`endif
    );

    // Behavioural ALU; illegal opcodes give a nonzero pattern so the driver's forcing is visible.
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = ~alu_a;
            default: alu_out = alu_a ^ 4'hA;
        endcase
    end

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s);
        int r;
        case (s)
            3'd0:    r = (int'(a) + int'(b)) % 16;
            3'd1:    r = (int'(a) - int'(b) + 16) % 16;
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a | b);
            3'd4:    r = 15 - int'(a);
            default: return 5'b1_0000;
        endcase
        return {1'b0, 4'(r)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            expq.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (expq.size() > 0) void'(expq.pop_front());
            end
            if (cmd_valid && cmd_ready) expq.push_back(model(cmd_a, cmd_b, cmd_sel));
        end
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (expq.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                chk("sb_rsp_data", 32'(rsp_data), 32'(expq[0][3:0]));
                chk("sb_rsp_err",  32'(rsp_err),  32'(expq[0][4]));
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) begin
            chk("send_ready", 32'(cmd_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_rsp", 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_one(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                           input logic [3:0] ed, input logic ee);
        send(a, b, s);
        wait_rsp();
        chk("lit_rsp_data", 32'(rsp_data), 32'(ed));
        chk("lit_rsp_err",  32'(rsp_err),  32'(ee));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [3:0] a4 [5];
        logic [3:0] b4 [5];
        logic [2:0] s4 [5];
        int acc;
        int base;
        logic r;

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b0;

        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        chk("rst_alu_a",     32'(alu_a),     32'd0);
        chk("rst_alu_b",     32'(alu_b),     32'd0);
        chk("rst_alu_sel",   32'(alu_sel),   32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        rst = 1'b0;
        chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // ADD 7+5, timing pinned cycle by cycle
        rsp_ready = 1'b1;
        send(4'd7, 4'd5, 3'b000);
        chk("add_t0_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("drive_alu_a",   32'(alu_a),   32'd7);
        chk("drive_alu_b",   32'(alu_b),   32'd5);
        chk("drive_alu_sel", 32'(alu_sel), 32'd0);
        chk("drive_valid",   32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("add_t2_valid", 32'(rsp_valid), 32'd1);
        chk("add_t2_data",  32'(rsp_data),  32'hC);
        chk("add_t2_err",   32'(rsp_err),   32'd0);
        @(posedge clk); #1;
        chk("add_done_valid", 32'(rsp_valid), 32'd0);

        run_one(4'd2, 4'd3, 3'b001, 4'hF, 1'b0);
        run_one(4'hA, 4'd0, 3'b100, 4'h5, 1'b0);
        run_one(4'd9, 4'd6, 3'b011, 4'hF, 1'b0);

        // Backpressure: five commands fit (one in flight + DEPTH buffered)
        rsp_ready = 1'b0;
        a4 = '{4'd1, 4'd8, 4'hC, 4'd1, 4'd0};
        b4 = '{4'd2, 4'd1, 4'hA, 4'd2, 4'd0};
        s4 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_a = a4[i]; cmd_b = b4[i]; cmd_sel = s4[i]; cmd_valid = 1'b1;
            r = cmd_ready;
            @(posedge clk); #1;
            if (r) acc++;
        end
        chk("full_ready_low", 32'(cmd_ready), 32'd0);
        cmd_a = 4'hF; cmd_b = 4'hF; cmd_sel = 3'b000;
        repeat (3) begin
            @(posedge clk); #1;
            chk("full_hold_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        chk("accepted_count", 32'(acc), 32'd5);
        chk("bp_head_valid", 32'(rsp_valid), 32'd1);
        chk("bp_head_data",  32'(rsp_data),  32'd3);
        base = n_rsp;
        rsp_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("bp_rsp_count", 32'(n_rsp - base), 32'd5);

        // Illegal opcode still reaches the ALU, response forced to zero with err
        send(4'd3, 4'd1, 3'b110);
        @(posedge clk); #1;
        chk("illegal_driven", 32'(alu_sel), 32'd6);
        wait_rsp();
        chk("illegal_data", 32'(rsp_data), 32'd0);
        chk("illegal_err",  32'(rsp_err),  32'd1);
        @(posedge clk); #1;
        run_one(4'd3, 4'd4, 3'b000, 4'd7, 1'b0);

        // Reset with one response pending and three queued
        rsp_ready = 1'b0;
        send(4'd1, 4'd1, 3'b000);
        send(4'd2, 4'd2, 3'b000);
        send(4'd3, 4'd3, 3'b000);
        send(4'd4, 4'd4, 3'b000);
        wait_rsp();
        base = n_rsp;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("post_rst_silent", 32'(rsp_valid), 32'd0);
        end
        chk("post_rst_rsp_count", 32'(n_rsp - base), 32'd0);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
